// File: rtl/main_mem_ctrl.sv
// Initiator-side controller for the main memory port: single/burst reads and writes,
// one memory beat per cycle, read data returned in issue order after RD_LAT cycles.
module main_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rEnable,
    output logic              mem_wEnable,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [LEN_W:0]    ONE  = (LEN_W+1)'(1);

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W:0]    cnt_reg;
    logic [LEN_W:0]    rcnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [RD_LAT-1:0] pend_reg;
    logic              rd_tap;
    logic [LEN_W:0]    beats;

    assign req_ready   = (state_reg == S_IDLE);
    assign wdata_ready = (state_reg == S_WRITE);
    assign busy        = (state_reg != S_IDLE);
    assign rd_tap      = pend_reg[RD_LAT-1];
    assign beats       = {1'b0, len_reg} + ONE;

    // One stage per cycle of memory latency; stage 0 marks the edge that sampled rEnable.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pend
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n) pend_reg[0] <= 1'b0;
                    else        pend_reg[0] <= mem_rEnable;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) pend_reg[gi] <= 1'b0;
                    else        pend_reg[gi] <= pend_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            len_reg     <= '0;
            cnt_reg     <= '0;
            rcnt_reg    <= '0;
            addr_reg    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_rEnable <= 1'b0;
            mem_wEnable <= 1'b0;
            mem_din     <= '0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= rd_tap;
            if (rd_tap) begin
                rdata    <= mem_dout;
                rcnt_reg <= rcnt_reg + ONE;
            end
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        len_reg  <= req_len;
                        cnt_reg  <= '0;
                        rcnt_reg <= '0;
                        addr_reg <= req_addr;
                        if (req_write) begin
                            state_reg <= S_WRITE;
                        end else begin
                            // First read beat goes out on the accept edge.
                            state_reg   <= S_READ;
                            mem_addr    <= req_addr;
                            mem_rEnable <= 1'b1;
                            cnt_reg     <= ONE;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_reg < beats) begin
                        mem_addr <= mem_addr + STEP;
                        cnt_reg  <= cnt_reg + ONE;
                    end else begin
                        mem_rEnable <= 1'b0;
                        state_reg   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rd_tap && rcnt_reg == {1'b0, len_reg}) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        mem_wEnable <= 1'b1;
                        mem_addr    <= addr_reg;
                        mem_din     <= wdata;
                        addr_reg    <= addr_reg + STEP;
                        cnt_reg     <= cnt_reg + ONE;
                        if (cnt_reg == {1'b0, len_reg}) begin
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        mem_wEnable <= 1'b0;
                    end
                end
                S_DONE: begin
                    mem_wEnable <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: instance A (RD_LAT=1) and instance B (RD_LAT=3)
// share one behavioural memory; only A ever writes it.
module tb_main_mem_ctrl;

    localparam logic [31:0] DBASE = 32'hCAFE0000;
    localparam logic [31:0] WBASE = 32'h5EED0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          errors = 0;
    int          checks = 0;

    logic        a_req_valid, a_req_write, a_wdata_valid;
    logic [31:0] a_req_addr, a_wdata;
    logic [3:0]  a_req_len;
    logic        a_req_ready, a_wdata_ready, a_rdata_valid, a_done, a_busy;
    logic        a_mem_rEnable, a_mem_wEnable;
    logic [31:0] a_rdata, a_mem_addr, a_mem_din, a_mem_dout;

    logic        b_req_valid, b_req_write, b_wdata_valid;
    logic [31:0] b_req_addr, b_wdata;
    logic [3:0]  b_req_len;
    logic        b_req_ready, b_wdata_ready, b_rdata_valid, b_done, b_busy;
    logic        b_mem_rEnable, b_mem_wEnable;
    logic [31:0] b_rdata, b_mem_addr, b_mem_din, b_mem_dout;

    main_mem_ctrl #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr), .req_len(a_req_len),
        .wdata(a_wdata), .wdata_valid(a_wdata_valid), .wdata_ready(a_wdata_ready),
        .rdata(a_rdata), .rdata_valid(a_rdata_valid), .done(a_done), .busy(a_busy),
        .mem_addr(a_mem_addr), .mem_rEnable(a_mem_rEnable), .mem_wEnable(a_mem_wEnable),
        .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    main_mem_ctrl #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_len(b_req_len),
        .wdata(b_wdata), .wdata_valid(b_wdata_valid), .wdata_ready(b_wdata_ready),
        .rdata(b_rdata), .rdata_valid(b_rdata_valid), .done(b_done), .busy(b_busy),
        .mem_addr(b_mem_addr), .mem_rEnable(b_mem_rEnable), .mem_wEnable(b_mem_wEnable),
        .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    // Behavioural memory; non-enabled cycles push a poison word so mistimed captures show up.
    logic [31:0] mem [0:4095];
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];

    always @(posedge clk) begin
        if (a_mem_wEnable) mem[a_mem_addr[13:2]] <= a_mem_din;
        a_pipe    <= a_mem_rEnable ? mem[a_mem_addr[13:2]] : 32'hDEADBEEF;
        b_pipe[0] <= b_mem_rEnable ? mem[b_mem_addr[13:2]] : 32'hDEADBEEF;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_dout = a_pipe;
    assign b_mem_dout = b_pipe[2];

    // Selected-instance view for the scenario that runs on both latencies.
    logic        s_sel;
    logic [31:0] x_addr, x_rdata;
    logic        x_ren, x_rv, x_done, x_rdy, x_busy;
    assign x_addr  = s_sel ? b_mem_addr    : a_mem_addr;
    assign x_rdata = s_sel ? b_rdata       : a_rdata;
    assign x_ren   = s_sel ? b_mem_rEnable : a_mem_rEnable;
    assign x_rv    = s_sel ? b_rdata_valid : a_rdata_valid;
    assign x_done  = s_sel ? b_done        : a_done;
    assign x_rdy   = s_sel ? b_req_ready   : a_req_ready;
    assign x_busy  = s_sel ? b_busy        : a_busy;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b want 1", a_req_ready);
        end
        checks++;
        if ({a_busy, a_mem_rEnable, a_mem_wEnable, a_done, a_rdata_valid, a_wdata_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a_flags: got %b want 000000",
                     {a_busy, a_mem_rEnable, a_mem_wEnable, a_done, a_rdata_valid, a_wdata_ready});
        end
        checks++;
        if ({a_mem_addr, a_mem_din, a_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_a_data: addr=%h din=%h rdata=%h want 0", a_mem_addr, a_mem_din, a_rdata);
        end
        checks++;
        if ({b_req_ready, b_busy, b_mem_wEnable, b_wdata_ready, b_mem_din} !== {1'b1, 35'h0}) begin
            errors++;
            $display("FAIL reset_b: ready=%b busy=%b wen=%b wready=%b din=%h want 1/0/0/0/0",
                     b_req_ready, b_busy, b_mem_wEnable, b_wdata_ready, b_mem_din);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0; a_req_len = 4'd0;
        tick();
        a_req_valid = 1'b0;
        checks++;
        if ({a_wdata_ready, a_req_ready, a_mem_wEnable} !== 3'b100) begin
            errors++; $display("FAIL sw_enter: wready/ready/wen=%b want 100", {a_wdata_ready, a_req_ready, a_mem_wEnable});
        end
        a_wdata = 32'h00221700; a_wdata_valid = 1'b1;
        tick();
        a_wdata_valid = 1'b0;
        checks++;
        if ({a_mem_wEnable, a_done} !== 2'b11) begin
            errors++; $display("FAIL sw_beat: wen/done=%b want 11", {a_mem_wEnable, a_done});
        end
        checks++;
        if (a_mem_addr !== 32'h0 || a_mem_din !== 32'h00221700) begin
            errors++; $display("FAIL sw_bus: addr=%h din=%h want 00000000 00221700", a_mem_addr, a_mem_din);
        end
        tick();
        checks++;
        if ({a_mem_wEnable, a_done, a_req_ready} !== 3'b001) begin
            errors++; $display("FAIL sw_end: wen/done/ready=%b want 001", {a_mem_wEnable, a_done, a_req_ready});
        end
    endtask

    task automatic test_single_read;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_len = 4'd0;
        tick();
        a_req_valid = 1'b0;
        checks++;
        if ({a_mem_rEnable, a_mem_wEnable} !== 2'b10 || a_mem_addr !== 32'h0) begin
            errors++; $display("FAIL sr_issue: ren/wen=%b addr=%h want 10 00000000", {a_mem_rEnable, a_mem_wEnable}, a_mem_addr);
        end
        tick();
        checks++;
        if ({a_mem_rEnable, a_rdata_valid, a_done} !== 3'b000) begin
            errors++; $display("FAIL sr_wait: ren/rv/done=%b want 000", {a_mem_rEnable, a_rdata_valid, a_done});
        end
        tick();
        checks++;
        if ({a_rdata_valid, a_done} !== 2'b11 || a_rdata !== 32'h00221700) begin
            errors++; $display("FAIL sr_data: rv/done=%b rdata=%h want 11 00221700", {a_rdata_valid, a_done}, a_rdata);
        end
        tick();
        checks++;
        if ({a_rdata_valid, a_done, a_req_ready} !== 3'b001) begin
            errors++; $display("FAIL sr_end: rv/done/ready=%b want 001", {a_rdata_valid, a_done, a_req_ready});
        end
    endtask

    task automatic test_burst_write;
        logic [5:0]  vld = 6'b110011;
        logic [31:0] exp_addr [6] = '{32'h00121800, 32'h00121804, 32'h0, 32'h0, 32'h00121808, 32'h0012180C};
        int beat = 0;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h00121800; a_req_len = 4'd3;
        tick();
        a_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_wdata_valid = vld[i];
            a_wdata = DBASE + 32'(beat);
            tick();
            checks++;
            if (a_mem_wEnable !== vld[i] || a_done !== (i == 5)) begin
                errors++; $display("FAIL bw_wen[%0d]: wen=%b done=%b want %b %b", i, a_mem_wEnable, a_done, vld[i], i == 5);
            end
            if (vld[i]) begin
                checks++;
                if (a_mem_addr !== exp_addr[i] || a_mem_din !== DBASE + 32'(beat)) begin
                    errors++;
                    $display("FAIL bw_bus[%0d]: addr=%h din=%h want %h %h", i, a_mem_addr, a_mem_din, exp_addr[i], DBASE + 32'(beat));
                end
                beat++;
            end
        end
        a_wdata_valid = 1'b0;
        tick();
        checks++;
        if ({a_mem_wEnable, a_done, a_req_ready} !== 3'b001) begin
            errors++; $display("FAIL bw_end: wen/done/ready=%b want 001", {a_mem_wEnable, a_done, a_req_ready});
        end
    endtask

    task automatic test_burst_read;
        for (int pass = 0; pass < 2; pass++) begin
            int lat = (pass == 0) ? 1 : 3;
            s_sel = (pass == 1);
            if (s_sel) begin
                b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h00121800; b_req_len = 4'd3;
            end else begin
                a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h00121800; a_req_len = 4'd3;
            end
            tick();
            for (int k = 0; k <= lat + 5; k++) begin
                checks++;
                if (x_ren !== (k <= 3) || (k <= 3 && x_addr !== 32'h00121800 + 32'(4 * k))) begin
                    errors++; $display("FAIL br_issue lat%0d k%0d: ren=%b addr=%h want %b", lat, k, x_ren, x_addr, k <= 3);
                end
                checks++;
                if (x_rv !== (k >= lat + 1 && k <= lat + 4) || x_done !== (k == lat + 4)) begin
                    errors++; $display("FAIL br_ret lat%0d k%0d: rv=%b done=%b", lat, k, x_rv, x_done);
                end
                if (k >= lat + 1 && k <= lat + 4) begin
                    checks++;
                    if (x_rdata !== DBASE + 32'(k - lat - 1)) begin
                        errors++; $display("FAIL br_data lat%0d k%0d: got %h want %h", lat, k, x_rdata, DBASE + 32'(k - lat - 1));
                    end
                end
                checks++;
                if (x_rdy !== (k > lat + 4)) begin
                    errors++; $display("FAIL br_ready lat%0d k%0d: got %b want %b", lat, k, x_rdy, k > lat + 4);
                end
                // Stray write request during the burst must be ignored.
                a_req_write = 1'b1; b_req_write = 1'b1;
                a_req_valid = !s_sel && (k == 1 || k == 2);
                b_req_valid = s_sel && (k == 1 || k == 2);
                tick();
            end
            checks++;
            if (x_busy !== 1'b0) begin
                errors++; $display("FAIL br_ignore lat%0d: busy=%b want 0", lat, x_busy);
            end
        end
        s_sel = 1'b0;
    endtask

    task automatic test_wrap;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'hFFFFFFFC; a_req_len = 4'd1;
        tick();
        a_req_valid = 1'b0;
        a_wdata_valid = 1'b1; a_wdata = WBASE;
        tick();
        a_wdata = WBASE + 32'd1;
        checks++;
        if (a_mem_addr !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_w0: addr=%h want fffffffc", a_mem_addr);
        end
        tick();
        a_wdata_valid = 1'b0;
        checks++;
        if (a_mem_addr !== 32'h0 || a_done !== 1'b1) begin
            errors++; $display("FAIL wrap_w1: addr=%h done=%b want 00000000 1", a_mem_addr, a_done);
        end
        tick();
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'hFFFFFFFC; a_req_len = 4'd1;
        tick();
        a_req_valid = 1'b0;
        checks++;
        if (a_mem_addr !== 32'hFFFFFFFC || a_mem_rEnable !== 1'b1) begin
            errors++; $display("FAIL wrap_r0: addr=%h ren=%b want fffffffc 1", a_mem_addr, a_mem_rEnable);
        end
        tick();
        checks++;
        if (a_mem_addr !== 32'h0 || a_mem_rEnable !== 1'b1) begin
            errors++; $display("FAIL wrap_r1: addr=%h ren=%b want 00000000 1", a_mem_addr, a_mem_rEnable);
        end
        tick();
        checks++;
        if (a_mem_rEnable !== 1'b0 || a_rdata_valid !== 1'b1 || a_rdata !== WBASE) begin
            errors++; $display("FAIL wrap_d0: ren=%b rv=%b rdata=%h want 0 1 %h", a_mem_rEnable, a_rdata_valid, a_rdata, WBASE);
        end
        tick();
        checks++;
        if ({a_rdata_valid, a_done} !== 2'b11 || a_rdata !== WBASE + 32'd1) begin
            errors++; $display("FAIL wrap_d1: rv/done=%b rdata=%h want 11 %h", {a_rdata_valid, a_done}, a_rdata, WBASE + 32'd1);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int n_rv = 0;
        int n_done = 0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h00121800; a_req_len = 4'd3;
        tick();
        a_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({a_mem_rEnable, a_mem_wEnable, a_rdata_valid, a_done, a_busy, a_req_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid: ren/wen/rv/done/busy/ready=%b want 000001",
                     {a_mem_rEnable, a_mem_wEnable, a_rdata_valid, a_done, a_busy, a_req_ready});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_rv += int'(a_rdata_valid);
            n_done += int'(a_done);
        end
        checks++;
        if (n_rv != 0 || n_done != 0) begin
            errors++; $display("FAIL rst_discard: rv_cycles=%0d done_cycles=%0d want 0 0", n_rv, n_done);
        end
        a_req_valid = 1'b1; a_req_addr = 32'h00121804; a_req_len = 4'd0;
        tick();
        a_req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_rdata_valid, a_done} !== 2'b11 || a_rdata !== DBASE + 32'd1) begin
            errors++; $display("FAIL rst_after: rv/done=%b rdata=%h want 11 %h", {a_rdata_valid, a_done}, a_rdata, DBASE + 32'd1);
        end
        tick();
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after_ready: got %b want 1", a_req_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; s_sel = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_len = '0; a_wdata = '0; a_wdata_valid = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_len = '0; b_wdata = '0; b_wdata_valid = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_burst_read();
        test_wrap();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
